thumb_decode_pipe: RTL and testbench

//  Buffered, parametrised successor of the single-cycle Thumb decoder: queues 16-bit halfwords from fetch,

---
 rtl/thumb_decode_pipe_pkg.sv | 34 +++
 rtl/thumb_decode_pipe_fifo.sv | 66 ++++++
 rtl/thumb_decode_pipe.sv | 260 ++++++++++++++++++++++++++
 tb/tb_thumb_decode_pipe.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/thumb_decode_pipe_pkg.sv
// Shared encodings for the buffered Thumb decoder: micro-op codes, condition
// default, link register index and the BL prefix/suffix tracker states.
package thumb_decode_pipe_pkg;

    localparam logic [4:0] UOP_NOP = 5'd0;
    localparam logic [4:0] UOP_ADD = 5'd1;
    localparam logic [4:0] UOP_SUB = 5'd2;
    localparam logic [4:0] UOP_MOV = 5'd3;
    localparam logic [4:0] UOP_CMP = 5'd4;
    localparam logic [4:0] UOP_EOR = 5'd5;
    localparam logic [4:0] UOP_LSL = 5'd6;
    localparam logic [4:0] UOP_LDR = 5'd7;
    localparam logic [4:0] UOP_STR = 5'd8;
    localparam logic [4:0] UOP_B   = 5'd9;
    localparam logic [4:0] UOP_BCC = 5'd10;
    localparam logic [4:0] UOP_BL  = 5'd11;

    localparam logic [3:0] COND_AL = 4'hE;
    localparam int         LR_SEL  = 14;

    typedef enum logic {
        BL_IDLE,
        BL_PREFIX
    } bl_state_e;

    function automatic logic is_bl_prefix(input logic [15:0] hw);
        return hw[15:11] == 5'b11110;
    endfunction

    function automatic logic is_bl_suffix(input logic [15:0] hw);
        return hw[15:11] == 5'b11111;
    endfunction

endpackage

// File: rtl/thumb_decode_pipe_fifo.sv
// Halfword queue between fetch and decode: DEPTH x 16, registered occupancy,
// async reset of pointers, synchronous flush.
module thumb_decode_pipe_fifo #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [15:0]   din_i,
    input  logic          pop_i,
    output logic [15:0]   dout_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [LW-1:0] level_o
);

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LW'(DEPTH));
    assign level_o = level_q;

endmodule

// File: rtl/thumb_decode_pipe.sv
// Buffered Thumb decoder: halfword queue, combinational decode, BL prefix
// tracker and a valid/ready output register feeding execute.
module thumb_decode_pipe
    import thumb_decode_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int SEL_W  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [15:0]            in_instr,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4:0]             uop,
    output logic                   num_to_rhs,
    output logic [DATA_W-1:0]      num,
    output logic [SEL_W-1:0]       sel_p0,
    output logic [SEL_W-1:0]       sel_p1,
    output logic [SEL_W-1:0]       sel_in,
    output logic [3:0]             cond,
    output logic                   explose,
    output logic [$clog2(DEPTH):0] level
);

    typedef struct packed {
        logic [4:0]        uop;
        logic              num_to_rhs;
        logic [DATA_W-1:0] num;
        logic [SEL_W-1:0]  sel_p0;
        logic [SEL_W-1:0]  sel_p1;
        logic [SEL_W-1:0]  sel_in;
        logic [3:0]        cond;
        logic              explose;
    } rec_t;

    function automatic rec_t nop_rec();
        rec_t r;
        r.uop        = UOP_NOP;
        r.num_to_rhs = 1'b0;
        r.num        = '0;
        r.sel_p0     = '0;
        r.sel_p1     = '0;
        r.sel_in     = '0;
        r.cond       = COND_AL;
        r.explose    = 1'b0;
        return r;
    endfunction

    function automatic rec_t explose_rec();
        rec_t r;
        r         = nop_rec();
        r.explose = 1'b1;
        return r;
    endfunction

    // Branch offsets arrive as 23-bit signed byte offsets and widen to num.
    function automatic logic [DATA_W-1:0] sext_num(input logic signed [22:0] v);
        return DATA_W'(v);
    endfunction

    function automatic rec_t decode_hw(input logic [15:0] hw);
        rec_t             r;
        logic [SEL_W-1:0] lo3, mid3, hi3, rd8;
        r    = nop_rec();
        lo3  = SEL_W'(hw[2:0]);
        mid3 = SEL_W'(hw[5:3]);
        hi3  = SEL_W'(hw[8:6]);
        rd8  = SEL_W'(hw[10:8]);
        casez (hw)
            16'b00000???????????: begin
                r.sel_p0 = mid3;
                r.sel_in = lo3;
                if (hw[10:6] == 5'd0) begin
                    r.uop = UOP_MOV;
                end else begin
                    r.uop        = UOP_LSL;
                    r.num        = DATA_W'(hw[10:6]);
                    r.num_to_rhs = 1'b1;
                end
            end
            16'b000110??????????: begin
                r.uop    = hw[9] ? UOP_SUB : UOP_ADD;
                r.sel_p0 = hi3;
                r.sel_p1 = mid3;
                r.sel_in = lo3;
            end
            16'b000111??????????: begin
                r.uop        = hw[9] ? UOP_SUB : UOP_ADD;
                r.sel_p0     = mid3;
                r.sel_in     = lo3;
                r.num        = DATA_W'(hw[8:6]);
                r.num_to_rhs = 1'b1;
            end
            16'b001?????????????: begin
                r.sel_p0     = rd8;
                r.sel_in     = rd8;
                r.num        = DATA_W'(hw[7:0]);
                r.num_to_rhs = 1'b1;
                case (hw[12:11])
                    2'b00: r.uop = UOP_MOV;
                    2'b01: begin
                        r.uop    = UOP_CMP;
                        r.sel_in = '0;
                    end
                    2'b10:   r.uop = UOP_ADD;
                    default: r.uop = UOP_SUB;
                endcase
            end
            16'b0100000001??????: begin
                r.uop    = UOP_EOR;
                r.sel_p0 = lo3;
                r.sel_p1 = mid3;
                r.sel_in = lo3;
            end
            16'b0110????????????: begin
                r.sel_p0     = mid3;
                r.num        = DATA_W'({hw[10:6], 2'b00});
                r.num_to_rhs = 1'b1;
                if (hw[11]) begin
                    r.uop    = UOP_LDR;
                    r.sel_in = lo3;
                end else begin
                    r.uop    = UOP_STR;
                    r.sel_p1 = lo3;
                end
            end
            16'b1101????????????: begin
                if (hw[11:9] == 3'b111) begin
                    r = explose_rec();
                end else begin
                    r.uop  = UOP_BCC;
                    r.cond = hw[11:8];
                    r.num  = sext_num(23'($signed({hw[7:0], 1'b0})));
                end
            end
            16'b11100???????????: begin
                r.uop = UOP_B;
                r.num = sext_num(23'($signed({hw[10:0], 1'b0})));
            end
            default: r = explose_rec();
        endcase
        return r;
    endfunction

    function automatic rec_t bl_rec(input logic [10:0] hi, input logic [10:0] lo);
        rec_t r;
        r        = nop_rec();
        r.uop    = UOP_BL;
        r.sel_in = SEL_W'(LR_SEL);
        r.num    = sext_num({hi, lo, 1'b0});
        return r;
    endfunction

    bl_state_e   state_q, state_d;
    rec_t        rec_q, rec_d;
    logic        out_valid_q, out_valid_d;
    logic [10:0] prefix_q, prefix_d;
    logic [15:0] head;
    logic        empty, full, push, pop, load_en;

    assign in_ready = !full && !flush;
    assign push     = in_valid && in_ready;
    assign load_en  = (!out_valid_q || out_ready) && !empty;

    thumb_decode_pipe_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .push_i  (push),
        .din_i   (in_instr),
        .pop_i   (pop),
        .dout_o  (head),
        .empty_o (empty),
        .full_o  (full),
        .level_o (level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= BL_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = BL_IDLE;
        end else if (load_en) begin
            case (state_q)
                BL_IDLE:   if (is_bl_prefix(head)) state_d = BL_PREFIX;
                BL_PREFIX: state_d = BL_IDLE;
                default:   state_d = BL_IDLE;
            endcase
        end
    end

    // An orphan prefix is reported without popping, so the halfword that
    // broke the pair decodes on its own at the next load.
    always_comb begin
        pop         = 1'b0;
        rec_d       = rec_q;
        out_valid_d = out_valid_q;
        prefix_d    = prefix_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else begin
            if (!out_valid_q || out_ready) out_valid_d = 1'b0;
            if (load_en) begin
                case (state_q)
                    BL_IDLE: begin
                        pop = 1'b1;
                        if (is_bl_prefix(head)) begin
                            prefix_d = head[10:0];
                        end else begin
                            rec_d       = decode_hw(head);
                            out_valid_d = 1'b1;
                        end
                    end
                    default: begin
                        out_valid_d = 1'b1;
                        if (is_bl_suffix(head)) begin
                            pop   = 1'b1;
                            rec_d = bl_rec(prefix_q, head[10:0]);
                        end else begin
                            rec_d = explose_rec();
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            rec_q       <= nop_rec();
        end else begin
            out_valid_q <= out_valid_d;
            rec_q       <= rec_d;
        end
    end

    always_ff @(posedge clk) begin
        prefix_q <= prefix_d;
    end

    assign out_valid  = out_valid_q;
    assign uop        = rec_q.uop;
    assign num_to_rhs = rec_q.num_to_rhs;
    assign num        = rec_q.num;
    assign sel_p0     = rec_q.sel_p0;
    assign sel_p1     = rec_q.sel_p1;
    assign sel_in     = rec_q.sel_in;
    assign cond       = rec_q.cond;
    assign explose    = rec_q.explose;

endmodule

// File: tb/tb_thumb_decode_pipe.sv
// Bench for thumb_decode_pipe: directed scenarios plus randomized traffic
// scored against a halfword-stream reference decoder.
module tb_thumb_decode_pipe;
    import thumb_decode_pipe_pkg::*;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int SEL_W  = 4;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic [15:0]       in_instr = 16'h0;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [4:0]        uop;
    logic              num_to_rhs;
    logic [DATA_W-1:0] num;
    logic [SEL_W-1:0]  sel_p0, sel_p1, sel_in;
    logic [3:0]        cond;
    logic              explose;
    logic [LW-1:0]     level;
    logic [63:0]       dut_rec;

    always #5 clk = ~clk;

    thumb_decode_pipe #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .uop(uop),
        .num_to_rhs(num_to_rhs), .num(num), .sel_p0(sel_p0), .sel_p1(sel_p1), .sel_in(sel_in),
        .cond(cond), .explose(explose), .level(level)
    );

    assign dut_rec = {9'd0, uop, num_to_rhs, num, sel_p0, sel_p1, sel_in, cond, explose};

    int checks_cnt = 0;
    int errors_cnt = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks_cnt++;
        if (act !== exp) begin
            errors_cnt++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    typedef struct {
        int uop; bit n2r; int num; int p0; int p1; int sin; int cond; bit ex;
    } mrec_t;

    function automatic mrec_t mk(int u, bit n2r, int n, int p0, int p1, int sin, int c, bit ex);
        mrec_t r;
        r.uop = u; r.n2r = n2r; r.num = n; r.p0 = p0; r.p1 = p1; r.sin = sin; r.cond = c; r.ex = ex;
        return r;
    endfunction

    function automatic logic [63:0] pack(input mrec_t r);
        return {9'd0, r.uop[4:0], r.n2r, r.num[31:0], r.p0[3:0], r.p1[3:0], r.sin[3:0], r.cond[3:0], r.ex};
    endfunction

    // Reference decode straight from the instruction table, field by field.
    function automatic mrec_t ref_decode(input logic [15:0] h);
        mrec_t r;
        int lo, mid, hi, r8, imm5;
        lo = int'(h[2:0]); mid = int'(h[5:3]); hi = int'(h[8:6]); r8 = int'(h[10:8]); imm5 = int'(h[10:6]);
        r = mk(UOP_NOP, 0, 0, 0, 0, 0, 14, 0);
        casez (h)
            16'b00000???????????:
                if (imm5 == 0) r = mk(UOP_MOV, 0, 0, mid, 0, lo, 14, 0);
                else           r = mk(UOP_LSL, 1, imm5, mid, 0, lo, 14, 0);
            16'b0001100?????????: r = mk(UOP_ADD, 0, 0, hi, mid, lo, 14, 0);
            16'b0001101?????????: r = mk(UOP_SUB, 0, 0, hi, mid, lo, 14, 0);
            16'b0001110?????????: r = mk(UOP_ADD, 1, hi, mid, 0, lo, 14, 0);
            16'b0001111?????????: r = mk(UOP_SUB, 1, hi, mid, 0, lo, 14, 0);
            16'b00100???????????: r = mk(UOP_MOV, 1, int'(h[7:0]), r8, 0, r8, 14, 0);
            16'b00101???????????: r = mk(UOP_CMP, 1, int'(h[7:0]), r8, 0, 0, 14, 0);
            16'b00110???????????: r = mk(UOP_ADD, 1, int'(h[7:0]), r8, 0, r8, 14, 0);
            16'b00111???????????: r = mk(UOP_SUB, 1, int'(h[7:0]), r8, 0, r8, 14, 0);
            16'b0100000001??????: r = mk(UOP_EOR, 0, 0, lo, mid, lo, 14, 0);
            16'b01100???????????: r = mk(UOP_STR, 1, imm5 * 4, mid, lo, 0, 14, 0);
            16'b01101???????????: r = mk(UOP_LDR, 1, imm5 * 4, mid, 0, lo, 14, 0);
            16'b1101????????????:
                if (int'(h[11:8]) >= 14) r.ex = 1;
                else r = mk(UOP_BCC, 0, int'($signed(h[7:0])) * 2, 0, 0, 0, int'(h[11:8]), 0);
            16'b11100???????????: r = mk(UOP_B, 0, int'($signed(h[10:0])) * 2, 0, 0, 0, 14, 0);
            default: r.ex = 1;
        endcase
        return r;
    endfunction

    mrec_t       exp_q[$];
    bit          pend = 0;
    logic [10:0] pend_hi = '0;

    function automatic void model_push(input logic [15:0] h);
        if (pend) begin
            pend = 0;
            if (h[15:11] == 5'b11111) begin
                exp_q.push_back(mk(UOP_BL, 0, int'($signed({pend_hi, h[10:0]})) * 2, 0, 0, 14, 14, 0));
                return;
            end
            exp_q.push_back(mk(UOP_NOP, 0, 0, 0, 0, 0, 14, 1));
        end
        if (h[15:11] == 5'b11110) begin
            pend = 1;
            pend_hi = h[10:0];
        end else begin
            exp_q.push_back(ref_decode(h));
        end
    endfunction

    logic [63:0] hold_rec = '0;
    bit          hold_vld = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            pend = 0;
            hold_vld = 0;
        end else begin
            check_eq("in_ready_rule", in_ready, (level != LW'(DEPTH)) && !flush);
            check_eq("level_bound", level <= LW'(DEPTH), 1);
            if (hold_vld) begin
                check_eq("hold_valid", out_valid, 1);
                check_eq("hold_rec", dut_rec, hold_rec);
            end
            if (out_valid && out_ready) begin
                check_eq("rec_available", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    check_eq("rec_stream", dut_rec, pack(exp_q[0]));
                    void'(exp_q.pop_front());
                end
            end
            if (flush) begin
                exp_q.delete();
                pend = 0;
            end else if (in_valid && in_ready) begin
                model_push(in_instr);
            end
            hold_vld = out_valid && !out_ready && !flush;
            hold_rec = dut_rec;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] hw);
        in_valid = 1'b1;
        in_instr = hw;
        step();
        in_valid = 1'b0;
    endtask

    task automatic expect_rec(input string tag, input mrec_t r);
        check_eq({tag, "_valid"}, out_valid, 1);
        check_eq(tag, dut_rec, pack(r));
    endtask

    function automatic logic [15:0] rand_hw();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0: return {5'b11110, r[10:0]};
            1: return {5'b11111, r[10:0]};
            2: return {4'b1101, r[11:0]};
            3: return {5'b11100, r[10:0]};
            4: return {5'b00000, r[10:0]};
            5: return {5'b00011, r[10:0]};
            6: return {3'b001, r[12:0]};
            7: return {10'b0100000001, r[5:0]};
            8: return {4'b0110, r[11:0]};
            default: return r[15:0];
        endcase
    endfunction

    mrec_t rst_rec, ex_rec, add_rec;
    int    acc;
    bit    ok;

    initial begin
        rst_rec = mk(UOP_NOP, 0, 0, 0, 0, 0, 14, 0);
        ex_rec  = mk(UOP_NOP, 0, 0, 0, 0, 0, 14, 1);
        add_rec = mk(UOP_ADD, 0, 0, 4, 5, 6, 14, 0);

        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_rec", dut_rec, pack(rst_rec));
        check_eq("reset_valid", out_valid, 0);
        check_eq("reset_level", level, 0);
        rst_n = 1'b1;
        step();
        check_eq("ready_after_reset", in_ready, 1);

        // ADD register form with one-cycle latency
        out_ready = 1'b1;
        send(16'h192E);
        check_eq("t1_latency", out_valid, 0);
        step();
        expect_rec("t1_add", add_rec);

        // conditional branch and reserved condition
        send(16'hD0FF);
        step();
        expect_rec("t2_bcc", mk(UOP_BCC, 0, -2, 0, 0, 0, 0, 0));
        send(16'hDE00);
        step();
        expect_rec("t2_udf", ex_rec);

        // BL pair produces exactly one record
        send(16'hF000);
        send(16'hF801);
        check_eq("t3_no_prefix_rec", out_valid, 0);
        step();
        expect_rec("t3_bl", mk(UOP_BL, 0, 2, 0, 0, 14, 14, 0));
        send(16'hE800);
        check_eq("t3_single", out_valid, 0);
        step();
        expect_rec("t3_e800", ex_rec);

        // orphan prefix keeps the following halfword
        send(16'hF000);
        send(16'h192E);
        step();
        expect_rec("t4_orphan", ex_rec);
        step();
        expect_rec("t4_add", add_rec);
        step();
        check_eq("t4_drained_valid", out_valid, 0);
        check_eq("t4_drained_level", level, 0);

        // backpressure fills output register plus queue
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1;
            in_instr = 16'h2000 + 16'(acc);
            ok = in_ready;
            step();
            if (ok) acc++;
        end
        in_valid = 1'b0;
        check_eq("t5_accepted", acc, 5);
        check_eq("t5_in_ready", in_ready, 0);
        check_eq("t5_level_full", level, DEPTH);
        expect_rec("t5_head", mk(UOP_MOV, 1, 0, 0, 0, 0, 14, 0));
        repeat (3) step();
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            check_eq("t5_drain_level", level, 4 - k);
            expect_rec("t5_order", mk(UOP_MOV, 1, k, 0, 0, 0, 14, 0));
        end
        step();
        check_eq("t5_empty", out_valid, 0);

        // flush discards queue, output and pending prefix
        out_ready = 1'b0;
        send(16'h2001);
        send(16'h2002);
        send(16'h2003);
        send(16'hF000);
        check_eq("t6_pre_level", level, 3);
        check_eq("t6_pre_valid", out_valid, 1);
        flush = 1'b1;
        in_valid = 1'b1;
        in_instr = 16'h2004;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check_eq("t6_flush_valid", out_valid, 0);
        check_eq("t6_flush_level", level, 0);
        out_ready = 1'b1;
        send(16'hF801);
        step();
        expect_rec("t6_lone_suffix", ex_rec);

        // asynchronous reset in the middle of traffic
        out_ready = 1'b0;
        send(16'h2005);
        send(16'h2006);
        send(16'h2007);
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_rec", dut_rec, pack(rst_rec));
        check_eq("t6_rst_valid", out_valid, 0);
        check_eq("t6_rst_level", level, 0);
        step();
        rst_n = 1'b1;
        step();
        check_eq("t6_post_rst_valid", out_valid, 0);
        check_eq("t6_post_rst_level", level, 0);

        // randomized traffic, light then heavy backpressure
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = rand_hw();
            flush     = ($urandom_range(0, 99) == 0);
            out_ready = flush ? 1'b0 : ($urandom_range(0, 3) < ((i < 1500) ? 3 : 1));
            step();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            step();
        end
        check_eq("drain_model_empty", exp_q.size(), 0);
        check_eq("drain_valid", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
